// File: rtl/eth_pcs_tx_sched.sv
// eth_pcs_tx_sched
//
// Frame scheduler between the MAC transmit stream and the 10G PCS transmit
// path. Converts a valid/ready stream of 64-bit MAC words into XGMII lane
// traffic: a start/preamble word, the payload, then a terminate (/T/) or an
// error (/E/) word, followed by a minimum run of idle words. Everything
// advances only while the gearbox asserts i_clk_en.
//
// Parameters:
//   N_CHANNELS     XGMII lanes per word (lane 0 = bits [7:0], first on wire)
//   W_BYTE         bits per lane
//   MIN_IPG_WORDS  idle words emitted after /T/ or /E/ (0..15)
//
// Ports:
//   i_clk, i_reset_n   PCS transmit clock, async active-low reset
//   i_clk_en           gearbox advance enable
//   i_mac_valid/o_mac_ready/i_mac_data/i_mac_keep/i_mac_last
//                      MAC transmit stream (keep all-ones except last word)
//   o_xgmii_ctrl/o_xgmii_data   registered XGMII lane control and data
//   o_underrun         one enabled-cycle pulse when a frame is aborted
//   o_frame_cnt, o_underrun_cnt frame statistics
//
// Build option: define ETH_PCS_TX_SCHED_STATS_EN to add o_frame_cnt and
// o_underrun_cnt. Without it the ports and counters do not exist.

module eth_pcs_tx_sched #(
  parameter int N_CHANNELS    = 8,
  parameter int W_BYTE        = 8,
  parameter int MIN_IPG_WORDS = 1
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_clk_en,
  input  logic                         i_mac_valid,
  output logic                         o_mac_ready,
  input  logic [N_CHANNELS*W_BYTE-1:0] i_mac_data,
  input  logic [N_CHANNELS-1:0]        i_mac_keep,
  input  logic                         i_mac_last,
  output logic [N_CHANNELS-1:0]        o_xgmii_ctrl,
  output logic [N_CHANNELS*W_BYTE-1:0] o_xgmii_data,
  output logic                         o_underrun
`ifdef ETH_PCS_TX_SCHED_STATS_EN
  ,
  output logic [31:0]                  o_frame_cnt,
  output logic [15:0]                  o_underrun_cnt
`endif
);

  localparam int DW = N_CHANNELS * W_BYTE;
  localparam int KW = $clog2(N_CHANNELS + 1);

  localparam logic [W_BYTE-1:0] CH_IDLE  = W_BYTE'(8'h07);
  localparam logic [W_BYTE-1:0] CH_START = W_BYTE'(8'hFB);
  localparam logic [W_BYTE-1:0] CH_PRE   = W_BYTE'(8'h55);
  localparam logic [W_BYTE-1:0] CH_SFD   = W_BYTE'(8'hD5);
  localparam logic [W_BYTE-1:0] CH_TERM  = W_BYTE'(8'hFD);
  localparam logic [W_BYTE-1:0] CH_ERR   = W_BYTE'(8'hFE);

  localparam logic [DW-1:0] IDLE_WORD = {N_CHANNELS{CH_IDLE}};
  localparam logic [DW-1:0] PRE_WORD  = {CH_SFD, {(N_CHANNELS-2){CH_PRE}}, CH_START};
  localparam logic [DW-1:0] TERM_WORD = {{(N_CHANNELS-1){CH_IDLE}}, CH_TERM};
  localparam logic [DW-1:0] ERR_WORD  = {N_CHANNELS{CH_ERR}};

  localparam logic [N_CHANNELS-1:0] CTRL_PRE = N_CHANNELS'(1);
  localparam logic [3:0]            IPG_LOAD = 4'(MIN_IPG_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_IPG
  } state_t;

  // With a zero gap the frame end drops straight back to IDLE.
  localparam state_t END_STATE = (MIN_IPG_WORDS == 0) ? ST_IDLE : ST_IPG;

  state_t                  state, state_next;
  logic                    term_pending, term_pending_next;
  logic [3:0]              gap_cnt, gap_next;
  logic [N_CHANNELS-1:0]   ctrl_next;
  logic [DW-1:0]           data_next;
  logic                    underrun_next;
  logic [KW-1:0]           keep_len;
  logic                    keep_run;
  logic [N_CHANNELS-1:0]   last_ctrl;
  logic [DW-1:0]           last_data;

  // Ready never looks at valid, and is withheld while the separate
  // terminate word of a full last word is still owed.
  assign o_mac_ready = (state == ST_DATA) && !term_pending && i_clk_en;

  // Length of the run of ones in keep starting at lane 0; an empty run
  // is treated as one byte so the terminate always has a lane to land in.
  always_comb begin
    keep_len = '0;
    keep_run = 1'b1;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (keep_run && i_mac_keep[i]) keep_len = KW'(i + 1);
      else                           keep_run = 1'b0;
    end
    if (keep_len == '0) keep_len = KW'(1);
  end

  // Short last word: data lanes, then /T/ in the first empty lane, then idles.
  always_comb begin
    last_ctrl = '0;
    last_data = i_mac_data;
    for (int k = 0; k < N_CHANNELS; k++) begin
      if (KW'(k) == keep_len) begin
        last_ctrl[k]                  = 1'b1;
        last_data[k*W_BYTE +: W_BYTE] = CH_TERM;
      end else if (KW'(k) > keep_len) begin
        last_ctrl[k]                  = 1'b1;
        last_data[k*W_BYTE +: W_BYTE] = CH_IDLE;
      end
    end
  end

  always_comb begin
    state_next        = state;
    term_pending_next = term_pending;
    gap_next          = gap_cnt;
    ctrl_next         = '1;
    data_next         = IDLE_WORD;
    underrun_next     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_mac_valid) state_next = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        ctrl_next  = CTRL_PRE;
        data_next  = PRE_WORD;
        state_next = ST_DATA;
      end
      ST_DATA: begin
        if (term_pending) begin
          data_next         = TERM_WORD;
          term_pending_next = 1'b0;
          state_next        = END_STATE;
          gap_next          = IPG_LOAD;
        end else if (!i_mac_valid) begin
          data_next     = ERR_WORD;
          underrun_next = 1'b1;
          state_next    = END_STATE;
          gap_next      = IPG_LOAD;
        end else if (!i_mac_last) begin
          ctrl_next = '0;
          data_next = i_mac_data;
        end else if (keep_len == KW'(N_CHANNELS)) begin
          ctrl_next         = '0;
          data_next         = i_mac_data;
          term_pending_next = 1'b1;
        end else begin
          ctrl_next  = last_ctrl;
          data_next  = last_data;
          state_next = END_STATE;
          gap_next   = IPG_LOAD;
        end
      end
      ST_IPG: begin
        if (gap_cnt <= 4'd1) begin
          gap_next   = 4'd0;
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_cnt - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Everything, including the underrun flag, only moves on enabled cycles.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= ST_IDLE;
      term_pending <= 1'b0;
      gap_cnt      <= 4'd0;
      o_xgmii_ctrl <= '1;
      o_xgmii_data <= IDLE_WORD;
      o_underrun   <= 1'b0;
    end else if (i_clk_en) begin
      state        <= state_next;
      term_pending <= term_pending_next;
      gap_cnt      <= gap_next;
      o_xgmii_ctrl <= ctrl_next;
      o_xgmii_data <= data_next;
      o_underrun   <= underrun_next;
    end
  end

`ifdef ETH_PCS_TX_SCHED_STATS_EN
  // A /T/ goes out either as the separate terminate word or inside a short last word.
  logic term_out;
  assign term_out = (state == ST_DATA) &&
                    (term_pending ||
                     (i_mac_valid && i_mac_last && keep_len != KW'(N_CHANNELS)));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_frame_cnt    <= '0;
      o_underrun_cnt <= '0;
    end else if (i_clk_en) begin
      if (term_out)      o_frame_cnt    <= o_frame_cnt + 32'd1;
      if (underrun_next) o_underrun_cnt <= o_underrun_cnt + 16'd1;
    end
  end
`endif

endmodule
